// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package pc_seq_pkg;
   localparam int unsigned PC_W = 16;
   localparam logic [PC_W-1:0] INSTR_BYTES = 16'd2;

   typedef enum logic [1:0] {BOOT, REQ, HOLD} state_t;
   typedef enum logic [1:0] {NONE, BR, JMP, JR} rkind_t;

   // Redirect priority: jr > jmp > br_take.
   function automatic rkind_t live_kind(input logic jr, input logic jmp, input logic br_take);
      rkind_t k;
      k = NONE;
      if (jr)
         k = JR;
      else if (jmp)
         k = JMP;
      else if (br_take)
         k = BR;
      return k;
   endfunction
endpackage

// File: rtl/pc_next_calc.sv
// Next-fetch-address select: live redirect, else buffered redirect, else sequential.
module pc_next_calc
   import pc_seq_pkg::*;
(
   input  logic [PC_W-1:0] cur,
   input  logic            jr,
   input  logic            jmp,
   input  logic            br_take,
   input  logic [12:0]     br_off,
   input  logic [PC_W-1:0] jr_tgt,
   input  rkind_t          pend_kind,
   input  logic [PC_W-1:0] pend_opnd,
   output rkind_t          sel_kind,
   output logic [PC_W-1:0] nxt
);
   logic [PC_W-1:0] lnk;
   logic [PC_W-1:0] opnd;

   assign lnk = cur + INSTR_BYTES;

   always_comb begin
      sel_kind = live_kind(jr, jmp, br_take);
      opnd     = (sel_kind == JR) ? jr_tgt : {3'b000, br_off};
      if (sel_kind == NONE) begin
         sel_kind = pend_kind;
         opnd     = pend_opnd;
      end
      case (sel_kind)
         JR:      nxt = opnd;
         JMP:     nxt = {lnk[PC_W-1:13], opnd[12:0]};
         BR:      nxt = lnk + {{(PC_W-13){opnd[12]}}, opnd[12:0]};
         default: nxt = lnk;
      endcase
   end
endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer with req/gnt handshake and one-entry redirect buffer.
// Optional odd-jr trap enabled by defining PC_SEQ_MISALIGN_TRAP_EN.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
   input  logic            CLK,
   input  logic            Reset_n,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            stall,
   input  logic            br_take,
   input  logic [12:0]     br_off,
   input  logic            jmp,
   input  logic            jr,
   input  logic [PC_W-1:0] jr_tgt,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] link,
   output logic            misalign
);
   state_t          state;
   rkind_t          pend_kind;
   logic [PC_W-1:0] pend_opnd;
   rkind_t          live;
   logic [PC_W-1:0] jr_eff;
   logic [PC_W-1:0] live_opnd;
   logic [PC_W-1:0] calc_cur;
   rkind_t          sel_kind;
   logic [PC_W-1:0] nxt;
   logic            trap;
   logic            halted;

`ifdef PC_SEQ_MISALIGN_TRAP_EN
   assign jr_eff = jr_tgt;
   assign trap   = (sel_kind == JR) && nxt[0];
`else
   assign jr_eff = jr_tgt & {{(PC_W-1){1'b1}}, 1'b0};
   assign trap   = 1'b0;
`endif

   assign live      = live_kind(jr, jmp, br_take);
   assign live_opnd = (live == JR) ? jr_eff : {3'b000, br_off};
   // At a grant the base is the address being granted; in HOLD it is the last granted pc.
   assign calc_cur  = (state == REQ) ? imem_addr : pc;

   pc_next_calc u_calc (
      .cur       (calc_cur),
      .jr        (jr),
      .jmp       (jmp),
      .br_take   (br_take),
      .br_off    (br_off),
      .jr_tgt    (jr_eff),
      .pend_kind ((state == REQ) ? pend_kind : NONE),
      .pend_opnd (pend_opnd),
      .sel_kind  (sel_kind),
      .nxt       (nxt)
   );

   always_ff @(posedge CLK) begin
      misalign <= 1'b0;
      if (!Reset_n) begin
         state     <= BOOT;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
         pc        <= RESET_PC;
         link      <= RESET_PC + INSTR_BYTES;
         pend_kind <= NONE;
         pend_opnd <= '0;
         halted    <= 1'b0;
      end else begin
         case (state)
            BOOT: begin
               state     <= REQ;
               imem_req  <= 1'b1;
               imem_addr <= RESET_PC;
            end
            REQ: begin
               if (imem_gnt) begin
                  pc   <= imem_addr;
                  link <= imem_addr + INSTR_BYTES;
                  if (sel_kind != NONE)
                     pend_kind <= NONE;
                  if (trap) begin
                     state    <= HOLD;
                     imem_req <= 1'b0;
                     halted   <= 1'b1;
                     misalign <= 1'b1;
                  end else begin
                     imem_addr <= nxt;
                     if (stall) begin
                        state    <= HOLD;
                        imem_req <= 1'b0;
                     end
                  end
               end else if (live != NONE) begin
                  pend_kind <= live;
                  pend_opnd <= live_opnd;
               end
            end
            default: begin
               if (!halted) begin
                  if (trap) begin
                     halted   <= 1'b1;
                     misalign <= 1'b1;
                  end else begin
                     if (sel_kind != NONE)
                        imem_addr <= nxt;
                     if (!stall) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                     end
                  end
               end
            end
         endcase
      end
   end
endmodule
